// File: rtl/regfile_writeback_arbiter.sv
// Purpose : merges single-cycle ALU writebacks and FIFO-buffered load writebacks onto one register-file write port.
// Latency : 1 cycle from selection to WEN/wsel/wdat; load results wait in a DEPTH-entry FIFO until they win.
// Backpressure: mem_ready drops when the FIFO is full; alu_stall holds the ALU for one cycle when the FIFO is forced to win.
//
// Ports:
//   CLK, nRST                  clock, synchronous active-low reset
//   alu_valid/wsel/wdat        ALU writeback request; alu_stall = not accepted this cycle
//   mem_valid/wsel/wdat        load writeback offer; mem_ready = FIFO has room
//   WEN, wsel, wdat            registered register-file write port
//   pending                    destination registers of live queued loads
//   fifo_count                 FIFO occupancy, dead entries included
module regfile_writeback_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_wsel,
    input  logic [31:0]              alu_wdat,
    output logic                     alu_stall,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_wsel,
    input  logic [31:0]              mem_wdat,
    output logic                     WEN,
    output logic [4:0]               wsel,
    output logic [31:0]              wdat,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [AW:0]   DEPTH_CNT  = (AW + 1)'(DEPTH);

    // FIFO storage. A slot's live bit is only ever set while the slot is
    // occupied, so live also implies occupied.
    logic [4:0]       ent_wsel [DEPTH];
    logic [31:0]      ent_wdat [DEPTH];
    logic [DEPTH-1:0] ent_live;
    logic [DEPTH-1:0] live_nxt;
    logic [DEPTH-1:0] kill;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic [SW-1:0]    starve;

    logic empty;
    logic head_live;
    logic any_live;
    logic forced;
    logic alu_win;
    logic alu_wr;
    logic head_wr;
    logic pop;
    logic push;
    logic push_live;

    assign empty     = (count == '0);
    assign head_live = !empty && ent_live[rd_ptr];
    assign any_live  = |ent_live;
    assign forced    = head_live && (starve == STARVE_LIM);

    assign alu_stall = alu_valid && forced;
    // An ALU request to r0 still wins arbitration; it just writes nothing.
    assign alu_win   = alu_valid && !forced;
    assign alu_wr    = alu_win && (alu_wsel != 5'd0);
    assign head_wr   = head_live && !alu_win;
    // Dead heads drain regardless of the ALU; live heads only when they win.
    assign pop       = !empty && (!ent_live[rd_ptr] || !alu_win);

    // No pop bypass: a full FIFO refuses even if it drains this cycle.
    assign mem_ready = (count < DEPTH_CNT);
    // r0 loads complete the handshake but never occupy a slot.
    assign push      = mem_valid && mem_ready && (mem_wsel != 5'd0);
    // A same-cycle load to the ALU's target is older in program order: store it dead.
    assign push_live = !(alu_wr && (mem_wsel == alu_wsel));

    assign fifo_count = count;

    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = alu_wr && ent_live[i] && (ent_wsel[i] == alu_wsel);
        end
    end

    always_comb begin
        live_nxt = ent_live & ~kill;
        if (pop) begin
            live_nxt[rd_ptr] = 1'b0;
        end
        if (push) begin
            live_nxt[wr_ptr] = push_live;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_live[i]) begin
                pending[ent_wsel[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    // Payload slots need no reset; the live bits guard them.
    always_ff @(posedge CLK) begin
        if (push) begin
            ent_wsel[wr_ptr] <= mem_wsel;
            ent_wdat[wr_ptr] <= mem_wdat;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ent_live <= '0;
            starve   <= '0;
            WEN      <= 1'b0;
            wsel     <= 5'd0;
            wdat     <= 32'd0;
        end else begin
            ent_live <= live_nxt;

            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase

            // Starvation guard: count ALU wins against a waiting live head.
            if (alu_win && head_live) begin
                if (starve != STARVE_LIM) begin
                    starve <= starve + SW'(1);
                end
            end else if (head_wr || !any_live) begin
                starve <= '0;
            end

            WEN <= alu_wr || head_wr;
            if (alu_wr) begin
                wsel <= alu_wsel;
                wdat <= alu_wdat;
            end else if (head_wr) begin
                wsel <= ent_wsel[rd_ptr];
                wdat <= ent_wdat[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;
    localparam int NVEC       = 31;

    logic        CLK;
    logic        nRST;
    logic        alu_valid;
    logic [4:0]  alu_wsel;
    logic [31:0] alu_wdat;
    logic        alu_stall;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_wsel;
    logic [31:0] mem_wdat;
    logic        WEN;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic [31:0] pending;
    logic [$clog2(DEPTH):0] fifo_count;

    regfile_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .alu_valid  (alu_valid),
        .alu_wsel   (alu_wsel),
        .alu_wdat   (alu_wdat),
        .alu_stall  (alu_stall),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wsel   (mem_wsel),
        .mem_wdat   (mem_wdat),
        .WEN        (WEN),
        .wsel       (wsel),
        .wdat       (wdat),
        .pending    (pending),
        .fifo_count (fifo_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of loads in program order plus a starve count.
    typedef struct {
        logic [4:0]  ws;
        logic [31:0] wd;
        bit          live;
    } ent_t;

    ent_t        q[$];
    int          starve;
    logic        m_wen;
    logic [4:0]  m_wsel;
    logic [31:0] m_wdat;
    logic        m_stall;
    logic        pre_stall;
    bit          known = 1'b0;

    typedef struct {
        logic        nrst;
        logic        av;
        logic [4:0]  aws;
        logic [31:0] awd;
        logic        mv;
        logic [4:0]  mws;
        logic [31:0] mwd;
        logic        e_stall;
        logic        e_wen;
        logic [4:0]  e_wsel;
        logic [31:0] e_wdat;
        logic [31:0] e_pend;
        int          e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t tbl[NVEC];

    function automatic vec_t mk(input int nrst, input int av, input int aws, input int awd,
                                input int mv, input int mws, input int mwd,
                                input int e_stall, input int e_wen, input int e_wsel,
                                input int e_wdat, input int e_pend, input int e_cnt, input int e_rdy);
        vec_t v;
        v.nrst    = 1'(nrst);
        v.av      = 1'(av);
        v.aws     = 5'(aws);
        v.awd     = 32'(awd);
        v.mv      = 1'(mv);
        v.mws     = 5'(mws);
        v.mwd     = 32'(mwd);
        v.e_stall = 1'(e_stall);
        v.e_wen   = 1'(e_wen);
        v.e_wsel  = 5'(e_wsel);
        v.e_wdat  = 32'(e_wdat);
        v.e_pend  = 32'(e_pend);
        v.e_cnt   = e_cnt;
        v.e_rdy   = 1'(e_rdy);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs against the
    // model, advance the model, then check the registered port after the edge.
    task automatic step(input logic r, input logic av, input logic [4:0] aws, input logic [31:0] awd,
                        input logic mv, input logic [4:0] mws, input logic [31:0] mwd);
        logic        head_live;
        logic        forced;
        logic        m_rdy;
        logic        alu_win;
        logic        alu_wr;
        logic        any_live;
        logic [31:0] pend;
        ent_t        e;
        @(negedge CLK);
        nRST      = r;
        alu_valid = av;
        alu_wsel  = aws;
        alu_wdat  = awd;
        mem_valid = mv;
        mem_wsel  = mws;
        mem_wdat  = mwd;
        #1;
        head_live = (q.size() > 0) && q[0].live;
        forced    = head_live && (starve == STARVE_MAX);
        m_rdy     = (q.size() < DEPTH);
        pend      = '0;
        any_live  = 1'b0;
        foreach (q[k]) begin
            if (q[k].live) begin
                pend[q[k].ws] = 1'b1;
                any_live      = 1'b1;
            end
        end
        m_stall   = av && forced;
        pre_stall = alu_stall;
        if (known) begin
            chk("alu_stall", 32'(alu_stall), 32'(m_stall));
            chk("mem_ready", 32'(mem_ready), 32'(m_rdy));
            chk("pending", pending, pend);
            chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        end
        if (!r) begin
            q.delete();
            starve = 0;
            m_wen  = 1'b0;
            m_wsel = 5'd0;
            m_wdat = 32'd0;
            known  = 1'b1;
        end else if (known) begin
            alu_win = av && !forced;
            alu_wr  = alu_win && (aws != 5'd0);
            if (alu_wr) begin
                m_wen  = 1'b1;
                m_wsel = aws;
                m_wdat = awd;
            end else if (!alu_win && head_live) begin
                m_wen  = 1'b1;
                m_wsel = q[0].ws;
                m_wdat = q[0].wd;
            end else begin
                m_wen = 1'b0;
            end
            if (alu_win && head_live) begin
                if (starve < STARVE_MAX) starve++;
            end else if ((!alu_win && head_live) || !any_live) begin
                starve = 0;
            end
            if (q.size() > 0 && (!q[0].live || !alu_win)) q.delete(0);
            if (alu_wr) begin
                foreach (q[k]) if (q[k].ws == aws) q[k].live = 1'b0;
            end
            if (mv && m_rdy && mws != 5'd0) begin
                e.ws   = mws;
                e.wd   = mwd;
                e.live = !(alu_wr && mws == aws);
                q.push_back(e);
            end
        end
        @(posedge CLK);
        #1;
        if (known) begin
            chk("WEN", 32'(WEN), 32'(m_wen));
            chk("wsel", 32'(wsel), 32'(m_wsel));
            chk("wdat", wdat, m_wdat);
        end
    endtask

    logic        r_av;
    logic [4:0]  r_aws;
    logic [31:0] r_awd;
    logic        r_mv;
    logic [4:0]  r_mws;
    logic [31:0] r_mwd;
    logic        r_rst;

    initial begin
        nRST = 1'b0; alu_valid = 1'b0; alu_wsel = '0; alu_wdat = '0;
        mem_valid = 1'b0; mem_wsel = '0; mem_wdat = '0;
        m_stall = 1'b0; starve = 0;

        //           nrst av aws awd           mv mws mwd        stall wen wsel wdat          pend         cnt rdy
        tbl[0]  = mk(0, 1, 5,  32'h0000_1234, 0, 0,  0,          0, 0, 0,  0,             0,           0, 1);
        tbl[1]  = mk(0, 1, 5,  32'h0000_1234, 0, 0,  0,          0, 0, 0,  0,             0,           0, 1);
        tbl[2]  = mk(1, 1, 5,  32'hDEAD_BEEF, 0, 0,  0,          0, 1, 5,  32'hDEAD_BEEF, 0,           0, 1);
        tbl[3]  = mk(1, 1, 0,  32'h0000_5555, 0, 0,  0,          0, 0, 5,  32'hDEAD_BEEF, 0,           0, 1);
        tbl[4]  = mk(1, 1, 0,  0,             1, 3,  32'h11,     0, 0, 5,  32'hDEAD_BEEF, 32'h8,       1, 1);
        tbl[5]  = mk(1, 1, 0,  0,             1, 4,  32'h22,     0, 0, 5,  32'hDEAD_BEEF, 32'h18,      2, 1);
        tbl[6]  = mk(1, 1, 0,  0,             1, 3,  32'h33,     0, 0, 5,  32'hDEAD_BEEF, 32'h18,      3, 1);
        tbl[7]  = mk(1, 0, 0,  0,             0, 0,  0,          0, 1, 3,  32'h11,        32'h18,      2, 1);
        tbl[8]  = mk(1, 0, 0,  0,             0, 0,  0,          0, 1, 4,  32'h22,        32'h8,       1, 1);
        tbl[9]  = mk(1, 0, 0,  0,             0, 0,  0,          0, 1, 3,  32'h33,        0,           0, 1);
        tbl[10] = mk(1, 0, 0,  0,             0, 0,  0,          0, 0, 3,  32'h33,        0,           0, 1);
        tbl[11] = mk(1, 0, 0,  0,             1, 7,  32'hAA,     0, 0, 3,  32'h33,        32'h80,      1, 1);
        tbl[12] = mk(1, 1, 1,  32'h101,       0, 0,  0,          0, 1, 1,  32'h101,       32'h80,      1, 1);
        tbl[13] = mk(1, 1, 2,  32'h102,       0, 0,  0,          0, 1, 2,  32'h102,       32'h80,      1, 1);
        tbl[14] = mk(1, 1, 10, 32'h103,       0, 0,  0,          0, 1, 10, 32'h103,       32'h80,      1, 1);
        tbl[15] = mk(1, 1, 11, 32'h104,       0, 0,  0,          1, 1, 7,  32'hAA,        0,           0, 1);
        tbl[16] = mk(1, 1, 11, 32'h104,       0, 0,  0,          0, 1, 11, 32'h104,       0,           0, 1);
        tbl[17] = mk(1, 0, 0,  0,             1, 9,  32'h1,      0, 0, 11, 32'h104,       32'h200,     1, 1);
        tbl[18] = mk(1, 1, 9,  32'h2,         1, 9,  32'h3,      0, 1, 9,  32'h2,         0,           2, 1);
        tbl[19] = mk(1, 0, 0,  0,             0, 0,  0,          0, 0, 9,  32'h2,         0,           1, 1);
        tbl[20] = mk(1, 0, 0,  0,             0, 0,  0,          0, 0, 9,  32'h2,         0,           0, 1);
        tbl[21] = mk(1, 1, 0,  0,             1, 12, 32'hC1,     0, 0, 9,  32'h2,         32'h1000,    1, 1);
        tbl[22] = mk(1, 1, 0,  0,             1, 13, 32'hC2,     0, 0, 9,  32'h2,         32'h3000,    2, 1);
        tbl[23] = mk(1, 1, 0,  0,             1, 14, 32'hC3,     0, 0, 9,  32'h2,         32'h7000,    3, 1);
        tbl[24] = mk(1, 1, 0,  0,             1, 15, 32'hC4,     0, 0, 9,  32'h2,         32'hF000,    4, 0);
        tbl[25] = mk(1, 1, 0,  0,             1, 16, 32'hC5,     1, 1, 12, 32'hC1,        32'hE000,    3, 1);
        tbl[26] = mk(1, 0, 0,  0,             1, 16, 32'hC5,     0, 1, 13, 32'hC2,        32'h1C000,   3, 1);
        tbl[27] = mk(1, 0, 0,  0,             0, 0,  0,          0, 1, 14, 32'hC3,        32'h18000,   2, 1);
        tbl[28] = mk(1, 0, 0,  0,             0, 0,  0,          0, 1, 15, 32'hC4,        32'h10000,   1, 1);
        tbl[29] = mk(1, 0, 0,  0,             0, 0,  0,          0, 1, 16, 32'hC5,        0,           0, 1);
        tbl[30] = mk(1, 0, 0,  0,             0, 0,  0,          0, 0, 16, 32'hC5,        0,           0, 1);

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].nrst, tbl[i].av, tbl[i].aws, tbl[i].awd, tbl[i].mv, tbl[i].mws, tbl[i].mwd);
            if (tbl[i].nrst) chk($sformatf("v%0d stall", i), 32'(pre_stall), 32'(tbl[i].e_stall));
            chk($sformatf("v%0d WEN", i), 32'(WEN), 32'(tbl[i].e_wen));
            chk($sformatf("v%0d wsel", i), 32'(wsel), 32'(tbl[i].e_wsel));
            chk($sformatf("v%0d wdat", i), wdat, tbl[i].e_wdat);
            chk($sformatf("v%0d pending", i), pending, tbl[i].e_pend);
            chk($sformatf("v%0d count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d ready", i), 32'(mem_ready), 32'(tbl[i].e_rdy));
        end

        // Reset in the middle of queued traffic: entries vanish, nothing is written.
        step(1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd20, 32'hE1);
        step(1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd21, 32'hE2);
        chk("midrst queued", 32'(fifo_count), 32'd2);
        chk("midrst pend", pending, 32'h0030_0000);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("midrst count", 32'(fifo_count), 32'd0);
        chk("midrst pend0", pending, 32'd0);
        chk("midrst ready", 32'(mem_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            chk($sformatf("midrst nowrite%0d", i), 32'(WEN), 32'd0);
        end

        // Randomized traffic against the model; small register range forces WAW collisions.
        r_av = 1'b0; r_aws = '0; r_awd = '0;
        for (int c = 0; c < 3000; c++) begin
            r_rst = ($urandom_range(0, 299) != 0);
            if (!m_stall) begin
                r_av  = ($urandom_range(0, 99) < 55);
                r_aws = 5'($urandom_range(0, 7));
                r_awd = $urandom();
            end
            r_mv  = ($urandom_range(0, 99) < 60);
            r_mws = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r_mwd = $urandom();
            step(r_rst, r_av, r_aws, r_awd, r_mv, r_mws, r_mwd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Writer end of the register file write port: merges writeback traffic from the single-cycle ALU path and the variable-latency memory (load) path onto one WEN/wsel/wdat port.
- Memory results are buffered in a small FIFO. The ALU has priority, with a starvation guard for the FIFO.
- Tracks queued destination registers (`pending`) for the hazard unit.
- Enforces write-after-write ordering by killing stale queued load writes.

Parameters:
- DEPTH, 4, memory-result FIFO entries (power of 2, ≥2).
- STARVE_MAX, 3, consecutive ALU-won cycles with a non-empty FIFO before the FIFO is forced to win.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  reset, synchronous, active-low.
- alu_valid  input  1  ALU result present this cycle.
- alu_wsel  input  5  ALU destination register.
- alu_wdat  input  32  ALU result word.
- alu_stall  output  1  combinational; ALU write not accepted, ALU must hold inputs.
- mem_valid  input  1  load result offered.
- mem_ready  output  1  combinational; FIFO can accept.
- mem_wsel  input  5  load destination register.
- mem_wdat  input  32  load data word.
- WEN  output  1  registered register-file write enable.
- wsel  output  5  registered write select.
- wdat  output  32  registered write data.
- pending  output  32  combinational; bit r=1 iff a live FIFO entry targets r.
- fifo_count  output  $clog2(DEPTH)+1  occupancy, including dead entries.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low on nRST.
  - On a rising CLK with nRST=0: FIFO empty, all entries dead, starve counter=0, WEN=0, wsel=0, wdat=0.
  - Combinational outputs after reset: pending=0, fifo_count=0, mem_ready=1, alu_stall=0.
  - Reset asserted mid-operation discards all queued entries; no write is issued for them.
- Enqueue: occurs when mem_valid & mem_ready.
  - mem_ready = (fifo_count < DEPTH); there is no same-cycle pop bypass.
  - mem_wsel==0 is accepted but not stored (handshake completes, no entry).
- Arbitration, evaluated each cycle. Head = oldest entry.
  - forced = FIFO head live & starve==STARVE_MAX.
  - alu_stall = alu_valid & forced.
  - If alu_valid & !forced: select the ALU write. If alu_wsel==0, no write, but this still counts as an ALU win.
  - Else if head live: select the head write and pop it.
  - A dead head is popped every cycle it is at head, independent of the ALU; no write is issued for it.
- Output latency: the selected write appears on WEN/wsel/wdat at the next rising edge (1-cycle latency). When nothing is selected, WEN=0 and wsel/wdat hold their previous values.
- Starve counter:
  - Increments when the ALU wins while a live head exists.
  - Clears when a live head is popped or the FIFO holds no live entry.
  - Saturates at STARVE_MAX.
- WAW kill: on an accepted ALU write to r≠0, every live FIFO entry with wsel==r becomes dead in the same edge. An incoming mem entry in the same cycle with mem_wsel==r is also stored dead, since the load is older in program order.
- pending: OR over live entries of one-hot(wsel). Killed entries clear their bit immediately; bit 0 is always 0.
- Simultaneous enqueue and pop: both occur; fifo_count is unchanged.
- Wrap-around: pointers wrap modulo DEPTH; entries are read back in FIFO order.

Test Plan:
- Reset with nRST=0 for 2 cycles while alu_valid=1 → WEN=0, wsel=0, wdat=0, pending=0, mem_ready=1, fifo_count=0; the first write appears 1 cycle after nRST=1.
- ALU only: alu_wsel=5, alu_wdat=0xDEADBEEF → next cycle WEN=1, wsel=5, wdat=0xDEADBEEF. Then alu_wsel=0 → WEN=0.
- Mem only: push r3=0x11, r4=0x22, r3=0x33 → writes appear in order on 3 consecutive cycles; pending=0x18 after the pushes, then 0 when drained.
- Contention/starvation (STARVE_MAX=3): FIFO holds r7=0xAA and the ALU is valid every cycle → 3 ALU writes, then alu_stall=1 for one cycle with a r7/0xAA write; the ALU's held write follows.
- WAW kill: queue r9=0x1, then an accepted ALU write r9=0x2 → pending[9] clears that edge; the dead entry is popped with no write; the final r9 write is 0x2 only. A same-cycle mem r9 push is also dropped.
- Full: DEPTH pushes with the ALU always valid and STARVE_MAX large → mem_ready=0 and fifo_count=DEPTH. After one pop, mem_ready=1 and a further push wraps correctly and drains in order.
